// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one stage per shift-amount bit, logical/rotate/arithmetic
// shifts in either direction, valid/ready handshake on both sides.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PIPE  = 1,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("pipelined_barrel_shifter: WIDTH must be a power of two and at least 2");
  end

  // Shift by s in one direction/mode; mode 11 and left arithmetic fall through to logical.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input int unsigned      s,
    input logic             dir,
    input logic [1:0]       mode
  );
    logic [WIDTH-1:0] r;
    if (dir) begin
      r = d << s;
      if (mode == 2'b01) r = r | (d >> (WIDTH - s));
    end else begin
      r = d >> s;
      if (mode == 2'b01) begin
        r = r | (d << (WIDTH - s));
      end else if (mode == 2'b10 && d[WIDTH-1]) begin
        // Earlier arithmetic right stages preserve the MSB, so it is still the original sign.
        r = r | ~({WIDTH{1'b1}} >> s);
      end
    end
    return r;
  endfunction

  logic advance;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned SHIFT = 1 << k;

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_out;
    logic [AMT_W-1:0] a_in;
    logic [AMT_W-1:0] a_out;
    logic             dir_in;
    logic             dir_out;
    logic [1:0]       mode_in;
    logic [1:0]       mode_out;
    logic             v_in;
    logic             v_out;

    if (k == 0) begin : g_src
      assign d_in    = in_data;
      assign a_in    = in_amt;
      assign dir_in  = in_dir;
      assign mode_in = in_mode;
      assign v_in    = in_valid;
    end else begin : g_src
      assign d_in    = g_stage[k-1].d_out;
      assign a_in    = g_stage[k-1].a_out;
      assign dir_in  = g_stage[k-1].dir_out;
      assign mode_in = g_stage[k-1].mode_out;
      assign v_in    = g_stage[k-1].v_out;
    end

    assign d_sh = a_in[k] ? shift_step(d_in, SHIFT, dir_in, mode_in) : d_in;

    // The last stage always feeds the output register directly.
    if (PIPE != 0 && k < AMT_W - 1) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_out    <= '0;
          a_out    <= '0;
          dir_out  <= 1'b0;
          mode_out <= 2'b00;
          v_out    <= 1'b0;
        end else if (advance) begin
          d_out    <= d_sh;
          a_out    <= a_in;
          dir_out  <= dir_in;
          mode_out <= mode_in;
          v_out    <= v_in;
        end
      end
    end else begin : g_comb
      assign d_out    = d_sh;
      assign a_out    = a_in;
      assign dir_out  = dir_in;
      assign mode_out = mode_in;
      assign v_out    = v_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= g_stage[AMT_W-1].v_out;
      out_data  <= g_stage[AMT_W-1].d_out;
    end
  end

  logic unused_tail;
  assign unused_tail = ^{g_stage[AMT_W-1].a_out, g_stage[AMT_W-1].dir_out,
                         g_stage[AMT_W-1].mode_out};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: PIPE=1 and PIPE=0 instances, directed vectors,
// stall/reset scenarios and a randomized run checked against a reference shift model.
module tb_pipelined_barrel_shifter;

  localparam int unsigned N_RAND = 10000;

  logic       clk;
  logic       rst_n;
  logic       iv    [2];
  logic       ird   [2];
  logic [7:0] idata [2];
  logic [2:0] iamt  [2];
  logic       idir  [2];
  logic [1:0] imode [2];
  logic       ov    [2];
  logic       ordy  [2];
  logic [7:0] odata [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic       acc_last [2];
  logic       ret_last [2];
  int         n_chk;
  int         n_fail;

  pipelined_barrel_shifter #(.WIDTH(8), .PIPE(0)) u_pipe0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ird[0]), .in_data(idata[0]), .in_amt(iamt[0]),
    .in_dir(idir[0]), .in_mode(imode[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0])
  );

  pipelined_barrel_shifter #(.WIDTH(8), .PIPE(1)) u_pipe1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ird[1]), .in_data(idata[1]), .in_amt(iamt[1]),
    .in_dir(idir[1]), .in_mode(imode[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word shifts on the original operand.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                           input logic dir, input logic [1:0] mode);
    logic [15:0] dd;
    dd = {d, d};
    if (dir) begin
      if (mode == 2'b01) return 8'((dd << amt) >> 8);
      return 8'(d << amt);
    end
    if (mode == 2'b01) return 8'(dd >> amt);
    if (mode == 2'b10) return 8'($signed(d) >>> amt);
    return 8'(d >> amt);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard retire/accept sampled mid-cycle, then step past the edge.
  task automatic tick();
    logic [7:0] e;
    int         qs;
    #4;
    for (int i = 0; i < 2; i++) begin
      ret_last[i] = ov[i] && ordy[i];
      acc_last[i] = iv[i] && ird[i];
      if (ret_last[i]) begin
        qs = (i == 0) ? q0.size() : q1.size();
        check($sformatf("sb_nonempty[%0d]", i), 32'(qs != 0), 32'd1);
        if (qs != 0) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("scoreboard[%0d]", i), 32'(odata[i]), 32'(e));
        end
      end
      if (acc_last[i]) begin
        e = ref_shift(idata[i], int'(iamt[i]), idir[i], imode[i]);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] d, input logic [2:0] a, input logic dir,
                          input logic [1:0] mode, input logic [7:0] exp);
    int         lat [2];
    logic [7:0] got [2];
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b1; idata[i] = d; iamt[i] = a; idir[i] = dir; imode[i] = mode;
      ordy[i] = 1'b1; lat[i] = 0; got[i] = 8'h00;
    end
    tick();
    for (int i = 0; i < 2; i++) iv[i] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = e;
          got[i] = odata[i];
        end
      end
      tick();
    end
    check($sformatf("lat_pipe1 d=%02h a=%0d dir=%0d m=%0d", d, a, dir, mode), 32'(lat[1]), 32'd3);
    check($sformatf("lat_pipe0 d=%02h a=%0d dir=%0d m=%0d", d, a, dir, mode), 32'(lat[0]), 32'd1);
    check($sformatf("data_pipe1 d=%02h a=%0d dir=%0d m=%0d", d, a, dir, mode), 32'(got[1]), 32'(exp));
    check($sformatf("data_pipe0 d=%02h a=%0d dir=%0d m=%0d", d, a, dir, mode), 32'(got[0]), 32'(exp));
  endtask

  initial begin
    int n_ret;
    int post;
    int sent [2];
    logic stalled;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; idata[i] = 8'h00; iamt[i] = 3'd0; idir[i] = 1'b0; imode[i] = 2'b00;
      ordy[i] = 1'b1; acc_last[i] = 1'b0; ret_last[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check($sformatf("reset_out_data[%0d]", i), 32'(odata[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("reset_in_ready[%0d]", i), 32'(ird[i]), 32'd1);
    @(posedge clk);
    #1;

    // Directed shifts
    send_one(8'hB4, 3'd3, 1'b0, 2'b00, 8'h16);
    send_one(8'hB4, 3'd3, 1'b0, 2'b01, 8'h96);
    send_one(8'hB4, 3'd2, 1'b0, 2'b10, 8'hED);
    send_one(8'h34, 3'd2, 1'b0, 2'b10, 8'h0D);
    send_one(8'hB4, 3'd1, 1'b1, 2'b00, 8'h68);
    send_one(8'hB4, 3'd1, 1'b1, 2'b01, 8'h69);
    send_one(8'hB4, 3'd1, 1'b1, 2'b10, 8'h68);
    send_one(8'hB4, 3'd1, 1'b1, 2'b11, 8'h68);
    send_one(8'hB4, 3'd3, 1'b0, 2'b11, 8'h16);
    for (int m = 0; m < 4; m++) begin
      send_one(8'hB4, 3'd0, 1'b0, 2'(m), 8'hB4);
      send_one(8'hB4, 3'd0, 1'b1, 2'(m), 8'hB4);
    end

    // Back-to-back beats with a 4-cycle output stall on the PIPE=1 instance
    iv[1] = 1'b1; idata[1] = 8'h01; iamt[1] = 3'd1; idir[1] = 1'b1; imode[1] = 2'b00;
    ordy[1] = 1'b1;
    stalled = 1'b0;
    n_ret = 0;
    post = 0;
    for (int c = 0; c < 40 && n_ret < 7; c++) begin
      if (!stalled && ov[1]) begin
        check("stall_first_data", 32'(odata[1]), 32'h02);
        ordy[1] = 1'b0;
        #1;
        check("stall_in_ready", 32'(ird[1]), 32'd0);
        for (int s = 0; s < 4; s++) begin
          check("stall_out_valid", 32'(ov[1]), 32'd1);
          check("stall_out_data", 32'(odata[1]), 32'h02);
          tick();
        end
        ordy[1] = 1'b1;
        stalled = 1'b1;
      end
      tick();
      if (acc_last[1]) begin
        if (iamt[1] == 3'd7) iv[1] = 1'b0;
        else iamt[1] = iamt[1] + 3'd1;
      end
      if (ret_last[1]) begin
        n_ret++;
        if (stalled) post++;
      end
    end
    iv[1] = 1'b0;
    check("stall_results", 32'(n_ret), 32'd7);
    check("stall_no_gaps", 32'(post), 32'd7);

    // Reset with beats in flight
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i] = 1'b1; idata[i] = 8'(8'h11 * (b + 1)); iamt[i] = 3'(b + 1);
        idir[i] = 1'b0; imode[i] = 2'b00; ordy[i] = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) iv[i] = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midreset_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check($sformatf("midreset_out_data[%0d]", i), 32'(odata[i]), 32'd0);
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 2; i++) check($sformatf("post_reset_idle[%0d]", i), 32'(ov[i]), 32'd0);
      tick();
    end
    send_one(8'hFF, 3'd4, 1'b1, 2'b00, 8'hF0);

    // Randomized traffic on both instances with random backpressure
    sent[0] = 0;
    sent[1] = 0;
    for (int c = 0; c < 60000 && (sent[0] < N_RAND || sent[1] < N_RAND); c++) begin
      for (int i = 0; i < 2; i++) begin
        ordy[i] = ($urandom_range(0, 9) < 7);
        if (!iv[i] && sent[i] < N_RAND && $urandom_range(0, 9) < 8) begin
          iv[i] = 1'b1;
          idata[i] = 8'($urandom);
          iamt[i] = 3'($urandom);
          idir[i] = 1'($urandom);
          imode[i] = 2'($urandom);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc_last[i]) begin
          sent[i]++;
          iv[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (8) tick();
    check("rand_sent_pipe0", 32'(sent[0]), 32'(N_RAND));
    check("rand_sent_pipe1", 32'(sent[1]), 32'(N_RAND));
    check("rand_drained_pipe0", 32'(q0.size()), 32'd0);
    check("rand_drained_pipe1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the datapath. It supports left and right shifts in logical, rotate and arithmetic modes. There is one registered stage per shift-amount bit, with valid/ready handshakes on both sides. It replaces the fixed 4-bit combinational right shifter/rotator and sits between the operand register file and the ALU result mux.

Parameters:
WIDTH, 8, data width in bits; must be a power of two and at least 2.
AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
PIPE, 1, 1 = register after every stage (latency AMT_W); 0 = one output register only (latency 1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  operand
in_amt  input  AMT_W  shift amount, 0..WIDTH-1
in_dir  input  1  0 = right (toward LSB), 1 = left
in_mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid and out_data clear to 0. in_ready reads 1 once reset is released.
- Stage k (k = 0..AMT_W-1, LSB first): if amt[k] is set, shift by 2^k in the captured direction and mode. Otherwise pass through unchanged.
- amt, dir and mode travel with the data through every stage register.
- Right logical: vacated MSBs fill with 0.
- Right rotate: bits leaving the LSB enter the MSB.
- Right arithmetic: vacated MSBs fill with the original in_data[WIDTH-1].
- Left logical: vacated LSBs fill with 0.
- Left rotate: bits leaving the MSB enter the LSB.
- Left arithmetic: identical to left logical.
- amt = 0 passes data unchanged in every mode.
- Latency: with PIPE=1, a beat accepted in cycle N appears on out_data/out_valid in cycle N+AMT_W. With PIPE=0, it appears in cycle N+1.
- Throughput: one beat per cycle when out_ready is held high.
- Handshake:
  - A transfer occurs on a clock edge where valid && ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_valid and out_ready only, with no path from in_valid.
  - During stall, every stage register, including valid bits, holds its value. out_data and out_valid stay stable until accepted.
  - When not stalled, valid bits advance one stage per cycle. Bubbles (valid = 0) propagate, and their data is don't-care.
- Simultaneous events:
  - With out_valid && out_ready && in_valid in the same cycle, the output beat retires and a new beat enters on that edge.
  - When out_ready rises after a stall, the pipeline resumes on the next edge with no lost or duplicated beats.
- Reset mid-operation: all in-flight beats are discarded, and no out_valid follows reset release until a new accepted beat has traversed the pipeline.
- Mode 11 must behave exactly as mode 00 and must not raise any flag.

Test Plan:
- WIDTH=8, PIPE=1, dir=0, mode=00, data 0xB4, amt=3 -> out_data 0x16 with out_valid exactly 3 cycles after acceptance.
- dir=0, mode=01, data 0xB4, amt=3 -> 0x96. dir=0, mode=10, data 0xB4, amt=2 -> 0xED. Same with data 0x34 -> 0x0D.
- dir=1: mode=00, data 0xB4, amt=1 -> 0x68. mode=01 -> 0x69. mode=10 -> 0x68. mode=11 -> 0x68. amt=0 in every mode -> 0xB4.
- Back-to-back beats 0x01 (amt 1..7) with out_ready=0 for 4 cycles mid-stream:
  - in_ready drops within the same cycle as the stall.
  - out_data holds 0x02.
  - After release, the results 0x02, 0x04, ..., 0x80 arrive in order with no gaps beyond the stall.
- Accept 3 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 and out_data=0 immediately. No stale result appears after release. A fresh beat 0xFF, amt=4, dir=1, mode=00 -> 0xF0.
- Randomised 10k beats, both PIPE values, random out_ready -> scoreboard matches a reference shift model with order preserved.
